// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the RV32I front end.
// Holds the fetch FSM state encoding, the NOP encoding loaded into the
// instruction register on reset, the default reset PC and the major opcode
// values that the control decoder also keys on.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection.
// Ports:
//   pc          in  32  address of the retiring instruction
//   imm_ext     in  32  sign-extended immediate (branch/jal offset)
//   alu_result  in  32  rs1 + imm for jalr
//   take_branch in  1   resolved branch taken
//   jump        in  1   jal
//   jalr        in  1   jalr (highest priority)
//   target      out 32  next PC
//   misaligned  out 1   target not word aligned
module next_pc_calc
(
  input  logic [31:0] pc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  input  logic        take_branch,
  input  logic        jump,
  input  logic        jalr,
  output logic [31:0] target,
  output logic        misaligned
);

  logic signed [31:0] pc_s;
  logic signed [31:0] imm_s;
  logic signed [31:0] rel_target;
  logic        [31:0] seq_target;
  logic        [31:0] jalr_target;

  always_comb begin
    pc_s        = $signed(pc);
    imm_s       = $signed(imm_ext);
    // Two's-complement add wraps modulo 2^32 exactly as the ISA requires.
    rel_target  = pc_s + imm_s;
    seq_target  = pc + 32'd4;
    // jalr clears bit 0 before the alignment check, so only bit 1 can trap.
    jalr_target = alu_result & ~32'd1;

    if (jalr)
      target = jalr_target;
    else if (take_branch || jump)
      target = $unsigned(rel_target);
    else
      target = seq_target;

    misaligned = (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and instruction fetch for the RV32I core.
// Owns the architectural PC, fetches one word at a time over a valid/ready
// request with a valid-only response, holds the instruction until execute
// retires it, and halts permanently (until reset) on a misaligned target.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  fetch request handshake
//   imem_rsp_valid, imem_rdata       fetch response
//   instr_valid, instr, pc, pc_plus4 instruction presented to decode/execute
//   retire, take_branch, jump, jalr, imm_ext, alu_result  retire outcome
//   trap                             misaligned target, fetch halted
//   instret                          retired-instruction count
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        take_branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic        trap,
  output logic [31:0] instret
);

  fetch_state_t state;
  logic [31:0]  target;
  logic         misaligned;

  next_pc_calc u_next_pc_calc (
    .pc          (pc),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .take_branch (take_branch),
    .jump        (jump),
    .jalr        (jalr),
    .target      (target),
    .misaligned  (misaligned)
  );

  // The address is the PC register itself, so it is stable while pending.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      pc_plus4       <= RESET_PC + 32'd4;
      instr          <= NOP_INSTR;
      instr_valid    <= 1'b0;
      imem_req_valid <= 1'b0;
      trap           <= 1'b0;
      instret        <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          // Out of reset the request is raised one cycle later; after a
          // retire it is already raised on the transition into FETCH.
          if (!imem_req_valid) begin
            imem_req_valid <= 1'b1;
          end else if (imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (retire) begin
            instret     <= instret + 32'd1;
            instr_valid <= 1'b0;
            if (misaligned) begin
              trap  <= 1'b1;
              state <= HALT;
            end else begin
              pc             <= target;
              pc_plus4       <= target + 32'd4;
              imem_req_valid <= 1'b1;
              state          <= FETCH;
            end
          end
        end
        HALT: begin
          imem_req_valid <= 1'b0;
          instr_valid    <= 1'b0;
          trap           <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: sequential fetch, branch, jump, jalr,
// wraparound, misalignment trap, backpressure and reset-in-EXEC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        take_branch;
  logic        jump;
  logic        jalr;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        trap;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .retire         (retire),
    .take_branch    (take_branch),
    .jump           (jump),
    .jalr           (jalr),
    .imm_ext        (imm_ext),
    .alu_result     (alu_result),
    .trap           (trap),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, accept it, return the
  // word one cycle later and check that it is presented for execute.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word);
    for (int i = 0; i < 10 && !imem_req_valid; i++) tick();
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("imem_addr", imem_addr, exp_addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("req_dropped", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rdata     = word;
    tick();
    imem_rsp_valid = 1'b0;
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, word);
    chk("exec_pc", pc, exp_addr);
  endtask

  task automatic do_retire(input logic br, input logic jmp, input logic jr,
                           input logic [31:0] imm, input logic [31:0] alu);
    take_branch = br;
    jump        = jmp;
    jalr        = jr;
    imm_ext     = imm;
    alu_result  = alu;
    retire      = 1'b1;
    tick();
    retire      = 1'b0;
    take_branch = 1'b0;
    jump        = 1'b0;
    jalr        = 1'b0;
    imm_ext     = 32'd0;
    alu_result  = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata = 32'd0;
    retire = 1'b0;
    take_branch = 1'b0;
    jump = 1'b0;
    jalr = 1'b0;
    imm_ext = 32'd0;
    alu_result = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_pc_plus4", pc_plus4, 32'h0000_0004);
    reset = 1'b0;

    // Three sequential instructions
    do_fetch(32'h0, 32'h0010_0093);
    do_retire(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("seq_req_after_retire", {31'd0, imem_req_valid}, 32'd1);
    do_fetch(32'h4, 32'h0020_0113);
    do_retire(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    do_fetch(32'h8, 32'h0030_0193);
    do_retire(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("seq_pc", pc, 32'h0000_000C);
    chk("seq_instret", instret, 32'd3);
    chk("seq_instr_valid", {31'd0, instr_valid}, 32'd0);

    // jal from 0xC by +0xF4 -> 0x100
    do_fetch(32'hC, 32'h0F40_006F);
    chk("jal_link", pc_plus4, 32'h0000_0010);
    do_retire(1'b0, 1'b1, 1'b0, 32'h0000_00F4, 32'd0);
    chk("jal_pc", pc, 32'h0000_0100);

    // Backward branch at 0x100 by -8 -> 0xF8
    do_fetch(32'h100, 32'hFE00_0CE3);
    do_retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
    chk("br_addr", imem_addr, 32'h0000_00F8);
    chk("br_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Request backpressure: ready low 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("bp_addr", imem_addr, 32'h0000_00F8);
    end
    imem_req_ready = 1'b1;
    tick();
    // Response delayed 4 cycles; spurious retire/ready in WAIT ignored
    retire = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("wait_pc", pc, 32'h0000_00F8);
    end
    retire = 1'b0;
    imem_req_ready = 1'b0;
    chk("wait_instret", instret, 32'd5);
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'h0000_8067;
    tick();
    imem_rsp_valid = 1'b0;
    chk("late_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("late_instr", instr, 32'h0000_8067);

    // jalr to 0x2005 -> 0x2004, no trap
    do_retire(1'b0, 1'b0, 1'b1, 32'd5, 32'h0000_2005);
    chk("jalr_pc", pc, 32'h0000_2004);
    chk("jalr_trap", {31'd0, trap}, 32'd0);
    chk("jalr_addr", imem_addr, 32'h0000_2004);

    // jalr to 0xFFFFFFFD -> 0xFFFFFFFC, then sequential wraps to 0
    do_fetch(32'h2004, 32'h0000_8067);
    chk("jalr_link", pc_plus4, 32'h0000_2008);
    do_retire(1'b0, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFD);
    chk("hi_pc", pc, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0013);
    chk("wrap_link", pc_plus4, 32'h0000_0000);
    do_retire(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("wrap_pc", pc, 32'h0000_0000);

    // Back to 0x2004, then misaligned jalr to 0x2006
    do_fetch(32'h0, 32'h0000_8067);
    do_retire(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_2005);
    do_fetch(32'h2004, 32'h0000_8067);
    do_retire(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_2006);
    chk("mis_trap", {31'd0, trap}, 32'd1);
    chk("mis_instret", instret, 32'd10);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    retire = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("halt_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", pc, 32'h0000_2004);
      chk("halt_trap", {31'd0, trap}, 32'd1);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    retire = 1'b0;
    chk("halt_instret", instret, 32'd10);

    // Leave HALT by reset, then reset in EXEC together with retire
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("unhalt_trap", {31'd0, trap}, 32'd0);
    do_fetch(32'h0, 32'h0040_0213);
    reset = 1'b1;
    retire = 1'b1;
    jump = 1'b1;
    imm_ext = 32'h0000_0040;
    tick();
    reset = 1'b0;
    retire = 1'b0;
    jump = 1'b0;
    imm_ext = 32'd0;
    chk("rx_pc", pc, 32'h0000_0000);
    chk("rx_instret", instret, 32'd0);
    chk("rx_instr", instr, 32'h0000_0013);
    chk("rx_trap", {31'd0, trap}, 32'd0);
    chk("rx_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rx_req_valid", {31'd0, imem_req_valid}, 32'd0);
    do_fetch(32'h0, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
